boot_mem_arb: RTL and testbench
===============================

Name: boot_mem_arb

Overview:
- Shares one single-port program SRAM between the SPI-device memory-write path and the core instruction-fetch port.
- Sequences boot: SPI loads the program; the block arms once the end-of-program marker word is written; on boot request it raises fetch_enable_o.
- Sits between the SPI slave, the core fetch interface and the instruction SRAM inside top_core.

Parameters:
BASE_ADDR, 32'h0000_0080, byte address of SRAM word 0
DEPTH, 256, SRAM depth in 32-bit words (power of two)
END_MARKER, 32'h0000_0fff, data word that terminates a program load
MAX_WAIT, 4, max consecutive cycles SPI may be refused while fetch wins (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
boot_en_i  in  1  level request to run loaded program
spi_req_i  in  1  SPI memory request
spi_we_i  in  1  1=write, 0=read
spi_addr_i  in  32  SPI byte address
spi_wdata_i  in  32  SPI write data
spi_gnt_o  out  1  SPI request accepted this cycle
spi_rvalid_o  out  1  SPI read data valid
spi_rdata_o  out  32  SPI read data
if_req_i  in  1  instruction fetch request (read only)
if_addr_i  in  32  fetch byte address
if_gnt_o  out  1  fetch accepted this cycle
if_rvalid_o  out  1  fetch data valid
if_rdata_o  out  32  fetch data
mem_req_o  out  1  SRAM access
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  $clog2(DEPTH)  SRAM word index
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid 1 cycle after read
fetch_enable_o  out  1  core fetch enable (registered)
load_count_o  out  16  accepted in-range SPI writes since last LOAD entry, saturating
state_o  out  2  00 LOAD, 01 ARMED, 10 RUN
err_o  out  1  sticky: out-of-range access seen

Behaviour:
- Reset: state LOAD; all outputs 0; load_count 0; wait counter 0; err_o 0.
- Grant is combinational; mem_* driven combinationally from the granted requester; at most one grant per cycle.
- Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored. In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
- Out-of-range request: still granted. mem_req_o=0. Read returns rvalid next cycle with rdata 32'hDEAD_BEEF. err_o set; cleared only by rst_i.
- Read response: rvalid asserted exactly 1 cycle after grant, routed by a registered owner bit. rdata = mem_rdata_i. Back-to-back reads give one response per cycle.
- LOAD:
  - if_gnt_o=0; fetch_enable_o=0; SPI granted whenever requested.
  - Each in-range granted SPI write increments load_count.
  - In-range write with wdata == END_MARKER is performed, then next state is ARMED.
- ARMED:
  - SPI still granted; writes still counted; a further marker write stays in ARMED.
  - boot_en_i=1 -> RUN. fetch_enable_o rises in the same cycle state_o shows RUN (1 cycle after boot_en_i sampled).
- RUN:
  - fetch_enable_o=1. Fetch has priority.
  - Wait counter increments each cycle spi_req_i is high and refused; resets on SPI grant or when spi_req_i is low.
  - When counter == MAX_WAIT, SPI wins that cycle and fetch is refused.
  - Only one requester present: it is granted.
- boot_en_i=0 while in RUN -> LOAD next cycle: fetch_enable_o=0, load_count cleared. A fetch read already granted still returns its rvalid.
- rst_i mid-operation: everything returns to reset values next edge; pending rvalid is dropped.
- load_count saturates at 16'hFFFF.

Optional Feature:
- Macro BOOT_MEM_ARB_WRITE_PROTECT_EN.
- Defined: SPI writes in RUN are granted but not performed (mem_req_o=0) and set err_o. SPI reads are unaffected.
- Undefined: SPI writes in RUN are performed normally.

Test Plan:
- Load: SPI writes words 0..31 at 0x80+4*i, word 31 = 0x00000fff -> state_o LOAD then ARMED after last write; load_count_o=32; fetch_enable_o=0.
- Boot: boot_en_i=1 in ARMED -> state RUN and fetch_enable_o=1 next cycle; fetch read of 0x80 returns word 0 with if_rvalid_o 1 cycle after if_gnt_o.
- Contention, MAX_WAIT=4: if_req_i held high, spi_req_i raised -> if_gnt_o for 4 cycles, then spi_gnt_o for 1 cycle, then if_gnt_o resumes; repeats every 5 cycles.
- Range: SPI read at 0x7C -> spi_rdata_o=0xDEADBEEF, mem_req_o=0, err_o=1 and stays 1.
- Reset mid-load: rst_i after 10 writes -> load_count_o=0, state LOAD, no rvalid next cycle.
- Stop: boot_en_i=0 in RUN -> fetch_enable_o=0 and state LOAD next cycle; with BOOT_MEM_ARB_WRITE_PROTECT_EN, an SPI write in RUN leaves SRAM unchanged and sets err_o.

Source files
------------

// File: rtl/boot_mem_arb.sv
// Program SRAM arbiter between the SPI loader and core instruction fetch, plus the LOAD/ARMED/RUN boot sequencer.
// Optional: define BOOT_MEM_ARB_WRITE_PROTECT_EN to refuse SPI writes into the SRAM while the core is running.
module boot_mem_arb #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0080,
  parameter int          DEPTH      = 256,
  parameter logic [31:0] END_MARKER = 32'h0000_0fff,
  parameter int          MAX_WAIT   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     boot_en_i,
  input  logic                     spi_req_i,
  input  logic                     spi_we_i,
  input  logic [31:0]              spi_addr_i,
  input  logic [31:0]              spi_wdata_i,
  output logic                     spi_gnt_o,
  output logic                     spi_rvalid_o,
  output logic [31:0]              spi_rdata_o,
  input  logic                     if_req_i,
  input  logic [31:0]              if_addr_i,
  output logic                     if_gnt_o,
  output logic                     if_rvalid_o,
  output logic [31:0]              if_rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [$clog2(DEPTH)-1:0] mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i,
  output logic                     fetch_enable_o,
  output logic [15:0]              load_count_o,
  output logic [1:0]               state_o,
  output logic                     err_o
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {LOAD = 2'b00, ARMED = 2'b01, RUN = 2'b10} state_t;

  state_t          state, next_state;
  logic [3:0]      wait_cnt;
  logic [15:0]     load_count;
  logic            fetch_enable, err;
  logic            spi_rv, if_rv, rsp_oor;
  logic            spi_gnt, if_gnt;
  logic            spi_in_range, if_in_range, spi_wr_blocked;
  logic [AW-1:0]   spi_idx, if_idx;
  logic            spi_load_write, marker_write;

  assign spi_in_range = (spi_addr_i >= BASE_ADDR) && ({1'b0, spi_addr_i} < LIMIT);
  assign if_in_range  = (if_addr_i >= BASE_ADDR) && ({1'b0, if_addr_i} < LIMIT);
  assign spi_idx      = AW'((spi_addr_i - BASE_ADDR) >> 2);
  assign if_idx       = AW'((if_addr_i - BASE_ADDR) >> 2);

`ifdef BOOT_MEM_ARB_WRITE_PROTECT_EN
  assign spi_wr_blocked = (state == RUN) && spi_we_i;
`else
  assign spi_wr_blocked = 1'b0;
`endif

  assign spi_load_write = spi_gnt && spi_we_i && spi_in_range;
  assign marker_write   = spi_load_write && (spi_wdata_i == END_MARKER);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= LOAD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (marker_write) next_state = ARMED;
      ARMED:   if (boot_en_i)    next_state = RUN;
      RUN:     if (!boot_en_i)   next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Fetch wins in RUN unless SPI has already been starved for MAX_WAIT cycles.
  always_comb begin
    spi_gnt     = 1'b0;
    if_gnt      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state != RUN) begin
      spi_gnt = spi_req_i;
    end else if (spi_req_i && (!if_req_i || wait_cnt == 4'(MAX_WAIT))) begin
      spi_gnt = 1'b1;
    end else begin
      if_gnt = if_req_i;
    end
    if (spi_gnt && spi_in_range && !spi_wr_blocked) begin
      mem_req_o   = 1'b1;
      mem_we_o    = spi_we_i;
      mem_addr_o  = spi_idx;
      mem_wdata_o = spi_we_i ? spi_wdata_i : 32'h0;
    end else if (if_gnt && if_in_range) begin
      mem_req_o  = 1'b1;
      mem_addr_o = if_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt     <= '0;
      load_count   <= '0;
      fetch_enable <= 1'b0;
      err          <= 1'b0;
      spi_rv       <= 1'b0;
      if_rv        <= 1'b0;
      rsp_oor      <= 1'b0;
    end else begin
      fetch_enable <= (next_state == RUN);
      if (state == RUN && spi_req_i && !spi_gnt) wait_cnt <= wait_cnt + 4'd1;
      else                                       wait_cnt <= '0;
      if (state == RUN && next_state == LOAD)
        load_count <= '0;
      else if (state != RUN && spi_load_write && load_count != 16'hFFFF)
        load_count <= load_count + 16'd1;
      if ((spi_gnt && (!spi_in_range || spi_wr_blocked)) || (if_gnt && !if_in_range))
        err <= 1'b1;
      spi_rv  <= spi_gnt && !spi_we_i;
      if_rv   <= if_gnt;
      rsp_oor <= spi_gnt ? !spi_in_range : !if_in_range;
    end
  end

  assign spi_gnt_o      = spi_gnt;
  assign if_gnt_o       = if_gnt;
  assign spi_rvalid_o   = spi_rv;
  assign if_rvalid_o    = if_rv;
  assign spi_rdata_o    = spi_rv ? (rsp_oor ? BAD_DATA : mem_rdata_i) : 32'h0;
  assign if_rdata_o     = if_rv  ? (rsp_oor ? BAD_DATA : mem_rdata_i) : 32'h0;
  assign fetch_enable_o = fetch_enable;
  assign load_count_o   = load_count;
  assign state_o        = state;
  assign err_o          = err;
endmodule

// File: tb/tb_boot_mem_arb.sv
// Randomized self-checking bench for boot_mem_arb with a cycle-level reference model and directed boot-flow checks.
// Honours BOOT_MEM_ARB_WRITE_PROTECT_EN when the design is built with it.
module tb_boot_mem_arb;
  localparam logic [31:0] BASE     = 32'h0000_0080;
  localparam int          DEPTH    = 256;
  localparam logic [31:0] MARKER   = 32'h0000_0fff;
  localparam int          MAX_WAIT = 4;
`ifdef BOOT_MEM_ARB_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, boot_en, spi_req, spi_we, if_req;
  logic [31:0] spi_addr, spi_wdata, if_addr;
  logic        spi_gnt, spi_rvalid, if_gnt, if_rvalid;
  logic [31:0] spi_rdata, if_rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        fetch_enable, err;
  logic [15:0] load_count;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sram      [DEPTH];
  bit          sram_init = 1'b0;
  logic [31:0] ref_mem   [DEPTH];
  logic [31:0] load_data [32];
  bit          g_spi, g_if, g_mreq;

  boot_mem_arb #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .END_MARKER(MARKER), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_i(rst), .boot_en_i(boot_en),
    .spi_req_i(spi_req), .spi_we_i(spi_we), .spi_addr_i(spi_addr), .spi_wdata_i(spi_wdata),
    .spi_gnt_o(spi_gnt), .spi_rvalid_o(spi_rvalid), .spi_rdata_o(spi_rdata),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .fetch_enable_o(fetch_enable), .load_count_o(load_count), .state_o(state), .err_o(err)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with one cycle read latency.
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= 32'h0;
      mem_rdata <= 32'h0;
      sram_init <= 1'b1;
    end else if (mem_req && mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end else if (mem_req) begin
      mem_rdata <= sram[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inRange(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Reference model: state as plain integers, updated once per cycle from the boot and arbitration rules.
  bit          model_on = 1'b0;
  int          m_state, m_wait, m_count;
  bit          m_err, m_spi_rv, m_if_rv;
  logic [31:0] m_spi_rd, m_if_rd;
  bit          e_spi, e_if, spi_ok, if_ok, blocked, e_mreq;

  task automatic resetModel();
    m_state = 0; m_wait = 0; m_count = 0;
    m_err = 1'b0; m_spi_rv = 1'b0; m_if_rv = 1'b0;
    m_spi_rd = 32'h0; m_if_rd = 32'h0;
  endtask

  always @(negedge clk) begin
    if (!model_on) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        resetModel();
        model_on = 1'b1;
      end
    end else begin
      spi_ok  = inRange(spi_addr);
      if_ok   = inRange(if_addr);
      blocked = WP && (m_state == 2) && spi_we;
      if (m_state != 2)                         begin e_spi = spi_req; e_if = 1'b0;   end
      else if (!spi_req)                        begin e_spi = 1'b0;    e_if = if_req; end
      else if (!if_req || m_wait == MAX_WAIT)   begin e_spi = 1'b1;    e_if = 1'b0;   end
      else                                      begin e_spi = 1'b0;    e_if = 1'b1;   end
      e_mreq = (e_spi && spi_ok && !blocked) || (e_if && if_ok);

      checkOutput("state", 32'(state), 32'(m_state));
      checkOutput("fetch_enable", 32'(fetch_enable), 32'(m_state == 2));
      checkOutput("load_count", 32'(load_count), 32'(m_count));
      checkOutput("err", 32'(err), 32'(m_err));
      checkOutput("spi_gnt", 32'(spi_gnt), 32'(e_spi));
      checkOutput("if_gnt", 32'(if_gnt), 32'(e_if));
      checkOutput("mem_req", 32'(mem_req), 32'(e_mreq));
      if (e_mreq) begin
        checkOutput("mem_we", 32'(mem_we), 32'(e_spi && spi_we));
        checkOutput("mem_addr", 32'(mem_addr), 32'(wordOf(e_spi ? spi_addr : if_addr)));
        if (e_spi && spi_we) checkOutput("mem_wdata", mem_wdata, spi_wdata);
      end
      checkOutput("spi_rvalid", 32'(spi_rvalid), 32'(m_spi_rv));
      checkOutput("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
      if (m_spi_rv) checkOutput("spi_rdata", spi_rdata, m_spi_rd);
      if (m_if_rv)  checkOutput("if_rdata", if_rdata, m_if_rd);

      m_spi_rv = e_spi && !spi_we;
      m_spi_rd = spi_ok ? ref_mem[wordOf(spi_addr)] : 32'hDEAD_BEEF;
      m_if_rv  = e_if;
      m_if_rd  = if_ok ? ref_mem[wordOf(if_addr)] : 32'hDEAD_BEEF;
      if (e_spi && spi_we && spi_ok && !blocked) ref_mem[wordOf(spi_addr)] = spi_wdata;
      if ((e_spi && (!spi_ok || blocked)) || (e_if && !if_ok)) m_err = 1'b1;
      if (m_state != 2 && e_spi && spi_we && spi_ok && m_count < 65535) m_count++;
      m_wait = (m_state == 2 && spi_req && !e_spi) ? m_wait + 1 : 0;
      case (m_state)
        0: if (e_spi && spi_we && spi_ok && spi_wdata == MARKER) m_state = 1;
        1: if (boot_en) m_state = 2;
        default: if (!boot_en) begin m_state = 0; m_count = 0; end
      endcase
      if (rst) resetModel();
    end
  end

  // Drives one cycle of inputs and records the combinational grants seen mid-cycle.
  task automatic applyStimulus(input bit r, input bit be, input bit sreq, input bit swe,
                               input logic [31:0] saddr, input logic [31:0] sdata,
                               input bit ireq, input logic [31:0] iaddr);
    rst = r; boot_en = be; spi_req = sreq; spi_we = swe;
    spi_addr = saddr; spi_wdata = sdata; if_req = ireq; if_addr = iaddr;
    @(negedge clk);
    g_spi = spi_gnt; g_if = if_gnt; g_mreq = mem_req;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0000_007C;
    if (r == 1) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
    return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b1; boot_en = 1'b0; spi_req = 1'b0; spi_we = 1'b0; if_req = 1'b0;
    spi_addr = '0; spi_wdata = '0; if_addr = '0;
    for (int i = 0; i < 32; i++) begin
      load_data[i] = $urandom;
      if (load_data[i] == MARKER) load_data[i] = MARKER ^ 32'h1;
    end
    load_data[31] = MARKER;

    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_state", 32'(state), 32'h0);
    checkOutput("reset_load_count", 32'(load_count), 32'h0);
    checkOutput("reset_fetch_enable", 32'(fetch_enable), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);

    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 1, BASE + 32'(4 * i), load_data[i], 0, 0);
    checkOutput("partial_load_count", 32'(load_count), 32'd10);
    applyStimulus(1, 0, 1, 0, BASE, 0, 0, 0);
    checkOutput("rst_load_count", 32'(load_count), 32'h0);
    checkOutput("rst_state", 32'(state), 32'h0);
    checkOutput("rst_no_rvalid", 32'(spi_rvalid), 32'h0);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 1, 1, BASE + 32'(4 * i), load_data[i], 0, 0);
      if (i == 30) checkOutput("load_state_before_marker", 32'(state), 32'h0);
    end
    checkOutput("armed_state", 32'(state), 32'h1);
    checkOutput("armed_load_count", 32'(load_count), 32'd32);
    checkOutput("armed_fetch_enable", 32'(fetch_enable), 32'h0);

    applyStimulus(0, 0, 1, 0, 32'h0000_007C, 0, 0, 0);
    checkOutput("oor_gnt", 32'(g_spi), 32'h1);
    checkOutput("oor_mem_req", 32'(g_mreq), 32'h0);
    checkOutput("oor_rvalid", 32'(spi_rvalid), 32'h1);
    checkOutput("oor_rdata", spi_rdata, 32'hDEAD_BEEF);
    checkOutput("oor_err", 32'(err), 32'h1);
    applyStimulus(0, 0, 1, 0, BASE + 32'(4 * 7), 0, 0, 0);
    checkOutput("err_sticky", 32'(err), 32'h1);
    checkOutput("readback_word7", spi_rdata, load_data[7]);

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("boot_state", 32'(state), 32'h2);
    checkOutput("boot_fetch_enable", 32'(fetch_enable), 32'h1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, BASE);
    checkOutput("fetch_gnt", 32'(g_if), 32'h1);
    checkOutput("fetch_rvalid", 32'(if_rvalid), 32'h1);
    checkOutput("fetch_word0", if_rdata, load_data[0]);

    for (int k = 0; k < 15; k++) begin
      applyStimulus(0, 1, 1, 0, BASE + 32'(4 * $urandom_range(0, 31)), 0,
                    1, BASE + 32'(4 * $urandom_range(0, 31)));
      checkOutput("contention_spi_gnt", 32'(g_spi), 32'((k % 5) == 4));
      checkOutput("contention_if_gnt", 32'(g_if), 32'((k % 5) != 4));
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 1, 1, BASE + 32'd20, 32'h1234_5678, 0, 0);
    checkOutput("run_write_mem_req", 32'(g_mreq), 32'(!WP));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stop_state", 32'(state), 32'h0);
    checkOutput("stop_fetch_enable", 32'(fetch_enable), 32'h0);
    checkOutput("stop_load_count", 32'(load_count), 32'h0);
    applyStimulus(0, 0, 1, 0, BASE + 32'd20, 0, 0, 0);
    checkOutput("run_write_effect", spi_rdata, WP ? load_data[5] : 32'h1234_5678);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 7) == 0) ? MARKER : $urandom;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, randAddr(), d,
                    $urandom_range(0, 2) != 0, randAddr());
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
